// File: rtl/l1_pkg.sv
// Shared definitions for the L1 instruction fetch path: FSM states, word size, buffer entry layout.
package l1_pkg;

    localparam int unsigned CORE_ADDR_W = 32;
    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0] pc;
        logic [CORE_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/l1i_fetch_fifo.sv
// Synchronous instruction buffer with flush, a registered head and a look-ahead count.
module l1i_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_next_c,
    output logic                       head_val_o,
    output logic [WIDTH-1:0]           head_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic             head_val_q;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             do_push, do_pop;

    // Flush overrides both push and pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && head_val_q && !flush_i;

    always_comb begin
        count_next_c = flush_i ? '0 : count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        rd_ptr_d     = flush_i ? '0 : rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d     = flush_i ? '0 : wr_ptr_q + PTR_W'(do_push);
        // A push into an otherwise-empty buffer becomes the head directly.
        if (count_next_c == '0) begin
            head_data_d = '0;
        end else if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            head_data_d = push_data_i;
        end else begin
            head_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_val_q  <= 1'b0;
            head_data_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_next_c;
            head_val_q  <= (count_next_c != '0);
            head_data_q <= head_data_d;
        end
    end

    assign head_val_o  = head_val_q;
    assign head_data_o = head_data_q;

endmodule

// File: rtl/l1i_fetch.sv
// Instruction fetch initiator: owns the fetch PC, issues one cache read at a time, handles redirects.
module l1i_fetch
    import l1_pkg::*;
#(
    parameter int unsigned       ADDR_W     = CORE_ADDR_W,
    parameter int unsigned       DATA_W     = CORE_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              core_req_val,
    output logic [ADDR_W-1:0] core_req_addr,
    input  logic              core_req_ack,
    input  logic [DATA_W-1:0] core_ack_data,
    input  logic              redir_val,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              inst_val,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_rdy
);

    localparam int unsigned       ENT_W      = ADDR_W + DATA_W;
    localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              req_val_q, req_val_d;
    logic              ack_c, push_c, pop_c, flush_c;
    logic [ADDR_W-1:0] redir_pc_a;
    logic [CNT_W-1:0]  count_next;
    logic [ENT_W-1:0]  head_data;

    assign ack_c      = core_req_ack && req_val_q;
    assign pop_c      = inst_val && inst_rdy;
    assign redir_pc_a = redir_pc & ALIGN_MASK;

    // DROP means the in-flight request belongs to a stale stream; its data is discarded on ack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        push_c  = 1'b0;
        flush_c = 1'b0;
        case (state_q)
            RUN: begin
                if (redir_val) begin
                    flush_c = 1'b1;
                    if (ack_c || !req_val_q) begin
                        pc_d = redir_pc_a;
                    end else begin
                        tgt_d   = redir_pc_a;
                        state_d = DROP;
                    end
                end else if (ack_c) begin
                    push_c = 1'b1;
                    pc_d   = pc_q + ADDR_W'(INSTR_BYTES);
                end
            end
            DROP: begin
                if (redir_val) begin
                    flush_c = 1'b1;
                    tgt_d   = redir_pc_a;
                end
                if (ack_c) begin
                    state_d = RUN;
                    pc_d    = redir_val ? redir_pc_a : tgt_q;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Only request when the word returned is guaranteed a slot.
    assign req_val_d = (count_next < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC_A;
            tgt_q     <= '0;
            req_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            req_val_q <= req_val_d;
        end
    end

    l1i_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_c),
        .push_data_i  ({pc_q, core_ack_data}),
        .pop_i        (pop_c),
        .flush_i      (flush_c),
        .count_next_c (count_next),
        .head_val_o   (inst_val),
        .head_data_o  (head_data)
    );

    assign core_req_val  = req_val_q;
    assign core_req_addr = pc_q;
    assign inst_pc       = head_data[ENT_W-1:DATA_W];
    assign inst_data     = head_data[DATA_W-1:0];

endmodule

// File: tb/tb_l1i_fetch.sv
// Self-checking bench for l1i_fetch: directed scenarios plus randomized traffic against a queue model.
module tb_l1i_fetch;
    import l1_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_val;
    logic [31:0] core_req_addr;
    logic        core_req_ack;
    logic [31:0] core_ack_data;
    logic        redir_val;
    logic [31:0] redir_pc;
    logic        inst_val;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: request state plus the buffered instruction stream as a queue.
    logic         m_val;
    logic [31:0]  m_addr;
    logic [31:0]  m_tgt;
    logic         m_drop;
    fetch_entry_t m_q[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    assign core_ack_data = data_of(core_req_addr);

    always #5 clk = ~clk;

    l1i_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req_val  (core_req_val),
        .core_req_addr (core_req_addr),
        .core_req_ack  (core_req_ack),
        .core_ack_data (core_ack_data),
        .redir_val     (redir_val),
        .redir_pc      (redir_pc),
        .inst_val      (inst_val),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_rdy      (inst_rdy)
    );

    task automatic model_step();
        logic        a;
        logic        pu;
        logic [31:0] r;
        if (!rst_n) begin
            m_val = 1'b0; m_addr = '0; m_tgt = '0; m_drop = 1'b0;
            m_q.delete();
            return;
        end
        a  = core_req_ack && m_val;
        r  = redir_pc & ~32'd3;
        pu = 1'b0;
        if (!m_drop) begin
            if (redir_val) begin
                if (a || !m_val) m_addr = r;
                else begin m_drop = 1'b1; m_tgt = r; end
            end else if (a) begin
                pu = 1'b1;
            end
        end else begin
            if (redir_val) m_tgt = r;
            if (a) begin m_drop = 1'b0; m_addr = m_tgt; end
        end
        if (redir_val) begin
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && inst_rdy) void'(m_q.pop_front());
            if (pu) begin
                m_q.push_back('{pc: m_addr, data: data_of(m_addr)});
                m_addr = m_addr + 32'd4;
            end
        end
        m_val = (m_q.size() < DEPTH);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; core_req_ack = 1'b0; redir_val = 1'b0; redir_pc = '0; inst_rdy = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; core_req_ack = 1'b1; redir_val = 1'b0; redir_pc = '0; inst_rdy = 1'b1;
        tick(); tick();
        n_tests++; if (core_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b want 0", core_req_val); end
        n_tests++; if (core_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", core_req_addr); end
        n_tests++; if (inst_val !== 1'b0) begin n_fail++; $display("FAIL reset_inst_val: got %b want 0", inst_val); end
        n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        n_tests++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data: got %h want 0", inst_data); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL first_req: got val=%b addr=%h want val=1 addr=0", core_req_val, core_req_addr); end
    endtask

    task automatic test_sequential();
        reset_dut();
        core_req_ack = 1'b1; inst_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'(4*i)) begin
                n_fail++; $display("FAIL seq_req[%0d]: got val=%b addr=%h want val=1 addr=%h", i, core_req_val, core_req_addr, 32'(4*i)); end
            n_tests++; if (inst_val !== 1'b1 || inst_pc !== 32'(4*(i-1)) || inst_data !== data_of(32'(4*(i-1)))) begin
                n_fail++; $display("FAIL seq_inst[%0d]: got val=%b pc=%h data=%h want pc=%h", i, inst_val, inst_pc, inst_data, 32'(4*(i-1))); end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        core_req_ack = 1'b1; inst_rdy = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        n_tests++; if (core_req_val !== 1'b0 || core_req_addr !== 32'h10 || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL full_stop: got val=%b addr=%h pc=%h want val=0 addr=10 pc=0", core_req_val, core_req_addr, inst_pc); end
        inst_rdy = 1'b1;
        tick();
        inst_rdy = 1'b0;
        n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'h10) begin
            n_fail++; $display("FAIL pulse_req: got val=%b addr=%h want val=1 addr=10", core_req_val, core_req_addr); end
        tick();
        n_tests++; if (core_req_val !== 1'b0 || core_req_addr !== 32'h14) begin
            n_fail++; $display("FAIL pulse_refill: got val=%b addr=%h want val=0 addr=14", core_req_val, core_req_addr); end
        tick(); tick();
        n_tests++; if (core_req_val !== 1'b0) begin n_fail++; $display("FAIL pulse_single: got val=%b want 0", core_req_val); end
        core_req_ack = 1'b0; inst_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (inst_val !== 1'b1 || inst_pc !== 32'(4*(k+1))) begin
                n_fail++; $display("FAIL drain[%0d]: got val=%b pc=%h want val=1 pc=%h", k, inst_val, inst_pc, 32'(4*(k+1))); end
            tick();
        end
        n_tests++; if (inst_val !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", inst_val); end
    endtask

    task automatic test_stall();
        reset_dut();
        core_req_ack = 1'b1; inst_rdy = 1'b1;
        tick(); tick();
        core_req_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'h8 || inst_val !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got val=%b addr=%h ival=%b want val=1 addr=8 ival=0", k, core_req_val, core_req_addr, inst_val); end
        end
        core_req_ack = 1'b1;
        tick();
        core_req_ack = 1'b0;
        n_tests++; if (core_req_addr !== 32'hC || inst_val !== 1'b1 || inst_pc !== 32'h8 || inst_data !== data_of(32'h8)) begin
            n_fail++; $display("FAIL stall_ack: got addr=%h ival=%b pc=%h want addr=c ival=1 pc=8", core_req_addr, inst_val, inst_pc); end
        tick();
        n_tests++; if (inst_val !== 1'b0) begin n_fail++; $display("FAIL stall_one_push: got ival=%b want 0", inst_val); end
    endtask

    task automatic test_redirect_pending();
        reset_dut();
        core_req_ack = 1'b1; inst_rdy = 1'b1;
        tick(); tick();
        core_req_ack = 1'b0; redir_val = 1'b1; redir_pc = 32'h103;
        tick();
        redir_val = 1'b0;
        n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'h8 || inst_val !== 1'b0) begin
            n_fail++; $display("FAIL rp_hold: got val=%b addr=%h ival=%b want val=1 addr=8 ival=0", core_req_val, core_req_addr, inst_val); end
        tick();
        n_tests++; if (core_req_addr !== 32'h8) begin n_fail++; $display("FAIL rp_hold2: got addr=%h want 8", core_req_addr); end
        core_req_ack = 1'b1;
        tick();
        n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'h100 || inst_val !== 1'b0) begin
            n_fail++; $display("FAIL rp_target: got val=%b addr=%h ival=%b want val=1 addr=100 ival=0", core_req_val, core_req_addr, inst_val); end
        tick();
        n_tests++; if (core_req_addr !== 32'h104 || inst_val !== 1'b1 || inst_pc !== 32'h100 || inst_data !== data_of(32'h100)) begin
            n_fail++; $display("FAIL rp_first: got addr=%h ival=%b pc=%h want addr=104 ival=1 pc=100", core_req_addr, inst_val, inst_pc); end
    endtask

    task automatic test_redirect_ack();
        reset_dut();
        core_req_ack = 1'b1; inst_rdy = 1'b1;
        tick();
        redir_val = 1'b1; redir_pc = 32'h40;
        tick();
        n_tests++; if (core_req_val !== 1'b1 || core_req_addr !== 32'h40 || inst_val !== 1'b0) begin
            n_fail++; $display("FAIL ra_same: got val=%b addr=%h ival=%b want val=1 addr=40 ival=0", core_req_val, core_req_addr, inst_val); end
        core_req_ack = 1'b0; redir_pc = 32'h80;
        tick();
        redir_val = 1'b0;
        n_tests++; if (core_req_addr !== 32'h40) begin n_fail++; $display("FAIL ra_hold: got addr=%h want 40", core_req_addr); end
        core_req_ack = 1'b1;
        tick();
        n_tests++; if (core_req_addr !== 32'h80 || inst_val !== 1'b0) begin
            n_fail++; $display("FAIL ra_target: got addr=%h ival=%b want addr=80 ival=0", core_req_addr, inst_val); end
        tick();
        n_tests++; if (core_req_addr !== 32'h84 || inst_val !== 1'b1 || inst_pc !== 32'h80) begin
            n_fail++; $display("FAIL ra_first: got addr=%h ival=%b pc=%h want addr=84 ival=1 pc=80", core_req_addr, inst_val, inst_pc); end
    endtask

    task automatic test_wrap_and_reset();
        reset_dut();
        core_req_ack = 1'b1; inst_rdy = 1'b1; redir_val = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        redir_val = 1'b0;
        n_tests++; if (core_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got addr=%h want fffffffc", core_req_addr); end
        tick();
        n_tests++; if (core_req_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_zero: got addr=%h pc=%h want addr=0 pc=fffffffc", core_req_addr, inst_pc); end
        core_req_ack = 1'b0;
        tick();
        rst_n = 1'b0; core_req_ack = 1'b1;
        tick();
        n_tests++; if (core_req_val !== 1'b0 || core_req_addr !== 32'h0 || inst_val !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got val=%b addr=%h ival=%b want val=0 addr=0 ival=0", core_req_val, core_req_addr, inst_val); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        fetch_entry_t h;
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            core_req_ack = ($urandom_range(0, 9) < 6);
            redir_val    = ($urandom_range(0, 9) == 0);
            redir_pc     = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 255));
            inst_rdy     = ($urandom_range(0, 9) < 7);
            tick();
            n_tests++; if (core_req_val !== m_val || core_req_addr !== m_addr) begin
                n_fail++; $display("FAIL rnd_req[%0d]: got val=%b addr=%h want val=%b addr=%h", c, core_req_val, core_req_addr, m_val, m_addr); end
            n_tests++; if (inst_val !== (m_q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_ival[%0d]: got %b want %b", c, inst_val, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                h = m_q[0];
                n_tests++; if ({inst_pc, inst_data} !== h) begin
                    n_fail++; $display("FAIL rnd_head[%0d]: got pc=%h data=%h want pc=%h data=%h", c, inst_pc, inst_data, h.pc, h.data); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; core_req_ack = 1'b0; redir_val = 1'b0; redir_pc = '0; inst_rdy = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_stall();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
